// File: rtl/vram_seq_pkg.sv
// Shared types and default timing for the VRAM write sequencer.
//   state_t  : write-cycle FSM states
//   rgb565_t : packed RGB565 colour
//   pixel_t  : {addr, color} payload at default widths
package vram_seq_pkg;

   localparam int unsigned DEF_ADDR_W     = 18;
   localparam int unsigned DEF_COLOR_W    = 16;
   localparam int unsigned DEF_DEPTH_LOG2 = 3;
   localparam int unsigned DEF_SETUP_CYC  = 1;
   localparam int unsigned DEF_STROBE_CYC = 2;
   localparam int unsigned CNT_W          = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_STROBE = 3'd2,
      ST_HOLD   = 3'd3,
      ST_SWAP   = 3'd4
   } state_t;

   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      rgb565_t               color;
   } pixel_t;

   // Phase counters count down to zero, so a phase of N cycles loads N-1.
   function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cyc);
      return CNT_W'(cyc - 1);
   endfunction

endpackage

// File: rtl/vram_write_sequencer_pixel_fifo.sv
// Synchronous FIFO with exact occupancy.
//   i_clk, i_rst_n     : clock, async active-low reset
//   i_push, i_data     : write request (ignored when full)
//   i_pop,  o_data     : read request (ignored when empty), head entry
//   o_full, o_empty    : status
//   o_level            : occupancy 0..DEPTH
module pixel_fifo #(
   parameter int unsigned DATA_W     = 34,
   parameter int unsigned DEPTH_LOG2 = 3
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_push,
   input  logic [DATA_W-1:0]     i_data,
   input  logic                  i_pop,
   output logic [DATA_W-1:0]     o_data,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [DEPTH_LOG2:0]   o_level
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned PTR_W = DEPTH_LOG2;
   localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [LVL_W-1:0]  r_count;
   logic              w_do_push;
   logic              w_do_pop;

   // A full FIFO refuses a push even when a pop happens in the same cycle.
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop  && !o_empty;

   assign o_full  = (r_count == LVL_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_level = r_count;
   assign o_data  = r_mem[r_rd_ptr];

   // Storage array; contents are don't-care until written.
   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + LVL_W'(1);
            2'b01:   r_count <= r_count - LVL_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/vram_write_sequencer.sv
// Buffers rasterized pixel writes and drives timed VRAM pad write cycles;
// owns the double-buffer select bit and swaps it only after drainage.
//   wb_clk_i, wb_rst_ni                 : clock, async active-low reset
//   pix_valid_i/pix_ready_o             : pixel handshake
//   pix_addr_i, pix_color_i             : pixel payload
//   swap_req_i, swap_done_o             : buffer swap request / completion pulse
//   busy_o, level_o                     : activity and FIFO occupancy
//   vram_raster_address/_color          : pad address/data buses
//   vram_write_pixel                    : pad write strobe
//   vram_offset                         : selected back buffer
module vram_write_sequencer
   import vram_seq_pkg::*;
#(
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned COLOR_W    = DEF_COLOR_W,
   parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2,
   parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
   parameter int unsigned STROBE_CYC = DEF_STROBE_CYC
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_ni,
   input  logic                  pix_valid_i,
   output logic                  pix_ready_o,
   input  logic [ADDR_W-1:0]     pix_addr_i,
   input  logic [COLOR_W-1:0]    pix_color_i,
   input  logic                  swap_req_i,
   output logic                  swap_done_o,
   output logic                  busy_o,
   output logic [DEPTH_LOG2:0]   level_o,
   output logic [ADDR_W-1:0]     vram_raster_address,
   output logic [COLOR_W-1:0]    vram_raster_color,
   output logic                  vram_write_pixel,
   output logic                  vram_offset
);

   localparam int unsigned PIX_W = ADDR_W + COLOR_W;

   if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
      $error("SETUP_CYC must be in 1..15");
   end
   if (STROBE_CYC < 1 || STROBE_CYC > 15) begin : g_bad_strobe
      $error("STROBE_CYC must be in 1..15");
   end

   state_t             r_state;
   state_t             w_next_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [ADDR_W-1:0]  r_addr;
   logic [ADDR_W-1:0]  w_addr_nxt;
   logic [COLOR_W-1:0] r_color;
   logic [COLOR_W-1:0] w_color_nxt;
   logic               r_strobe;
   logic               w_strobe_nxt;
   logic               r_offset;
   logic               w_offset_nxt;
   logic               r_swap_done;
   logic               w_swap_done_nxt;
   logic               r_swap_pending;
   logic               w_swap_pending_nxt;
   logic               r_ready_en;

   logic               w_fifo_push;
   logic               w_fifo_pop;
   logic               w_fifo_full;
   logic               w_fifo_empty;
   logic [PIX_W-1:0]   w_fifo_rd;

   // Ready is withheld while a swap is pending so the swap acts as a fence.
   assign pix_ready_o = r_ready_en && !w_fifo_full && !r_swap_pending;
   assign w_fifo_push = pix_valid_i && pix_ready_o;
   assign busy_o      = !w_fifo_empty || (r_state != ST_IDLE) || r_swap_pending;

   assign vram_raster_address = r_addr;
   assign vram_raster_color   = r_color;
   assign vram_write_pixel    = r_strobe;
   assign vram_offset         = r_offset;
   assign swap_done_o         = r_swap_done;

   pixel_fifo #(
      .DATA_W     (PIX_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .i_clk   (wb_clk_i),
      .i_rst_n (wb_rst_ni),
      .i_push  (w_fifo_push),
      .i_data  ({pix_addr_i, pix_color_i}),
      .i_pop   (w_fifo_pop),
      .o_data  (w_fifo_rd),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_level (level_o)
   );

   // State register.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; pending pixels always win over a pending swap.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (!w_fifo_empty) begin
               w_next_state = ST_SETUP;
            end else if (r_swap_pending) begin
               w_next_state = ST_SWAP;
            end
         end
         ST_SETUP:  if (r_cnt == '0) w_next_state = ST_STROBE;
         ST_STROBE: if (r_cnt == '0) w_next_state = ST_HOLD;
         ST_HOLD:   w_next_state = ST_IDLE;
         ST_SWAP:   w_next_state = ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
   end

   // Output logic: next values of the registered pad signals, counter and pop.
   always_comb begin
      w_fifo_pop         = 1'b0;
      w_cnt_nxt          = r_cnt;
      w_addr_nxt         = r_addr;
      w_color_nxt        = r_color;
      w_strobe_nxt       = 1'b0;
      w_offset_nxt       = r_offset;
      w_swap_done_nxt    = 1'b0;
      w_swap_pending_nxt = r_swap_pending || swap_req_i;
      case (r_state)
         ST_IDLE: begin
            if (!w_fifo_empty) begin
               w_fifo_pop  = 1'b1;
               w_addr_nxt  = w_fifo_rd[PIX_W-1 -: ADDR_W];
               w_color_nxt = w_fifo_rd[COLOR_W-1:0];
               w_cnt_nxt   = cnt_load(SETUP_CYC);
            end else if (r_swap_pending) begin
               // Offset and done pulse are registered on entry to SWAP.
               w_offset_nxt    = !r_offset;
               w_swap_done_nxt = 1'b1;
            end
         end
         ST_SETUP: begin
            if (r_cnt == '0) begin
               w_cnt_nxt    = cnt_load(STROBE_CYC);
               w_strobe_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         ST_STROBE: begin
            if (r_cnt != '0) begin
               w_cnt_nxt    = r_cnt - CNT_W'(1);
               w_strobe_nxt = 1'b1;
            end
         end
         ST_SWAP: begin
            // Requests arriving here are redundant with the one being served.
            w_swap_pending_nxt = 1'b0;
         end
         default: ;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_cnt          <= '0;
         r_addr         <= '0;
         r_color        <= '0;
         r_strobe       <= 1'b0;
         r_offset       <= 1'b0;
         r_swap_done    <= 1'b0;
         r_swap_pending <= 1'b0;
         r_ready_en     <= 1'b0;
      end else begin
         r_cnt          <= w_cnt_nxt;
         r_addr         <= w_addr_nxt;
         r_color        <= w_color_nxt;
         r_strobe       <= w_strobe_nxt;
         r_offset       <= w_offset_nxt;
         r_swap_done    <= w_swap_done_nxt;
         r_swap_pending <= w_swap_pending_nxt;
         r_ready_en     <= 1'b1;
      end
   end

endmodule
